// File: rtl/lif_neuron_update.sv
// Time-multiplexed leaky integrate-and-fire update engine: snapshots noise and
// synaptic current on step, then updates one membrane potential per clock.
module lif_neuron_update #(
    parameter int buffer_size = 32,
    parameter int Num_Neurons = 16,
    parameter int THRESHOLD   = 1000,
    parameter int V_RESET     = 0,
    parameter int LEAK_SHIFT  = 4,
    parameter int NOISE_SHIFT = 8,
    parameter int REFRACT     = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              step,
    input  logic [Num_Neurons*buffer_size-1:0] noise_array,
    input  logic [Num_Neurons*buffer_size-1:0] syn_array,
    output logic [Num_Neurons-1:0]            spikes,
    output logic                              busy,
    output logic                              done,
    output logic                              noise_adv
);

    localparam int IDX_W = (Num_Neurons > 1) ? $clog2(Num_Neurons) : 1;
    localparam int EXT_W = buffer_size + 2;

    localparam logic [IDX_W-1:0]              LAST_IDX  = IDX_W'(Num_Neurons - 1);
    localparam logic signed [buffer_size-1:0] THR_V     = buffer_size'(THRESHOLD);
    localparam logic signed [buffer_size-1:0] RST_V     = buffer_size'(V_RESET);
    localparam logic [7:0]                    REFR_LOAD = 8'(REFRACT);
    localparam logic signed [EXT_W-1:0]       SAT_MAX   = (EXT_W'(1) << (buffer_size - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0]       SAT_MIN   = -(EXT_W'(1) << (buffer_size - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPD,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [IDX_W-1:0]              idx;
    logic signed [buffer_size-1:0] noise_snap [Num_Neurons];
    logic signed [buffer_size-1:0] syn_snap   [Num_Neurons];
    logic signed [buffer_size-1:0] v_mem      [Num_Neurons];
    logic [7:0]                    refr       [Num_Neurons];
    logic [Num_Neurons-1:0]        spike_acc;
    logic [Num_Neurons-1:0]        spike_acc_nx;

    logic signed [buffer_size-1:0] v_cur;
    logic signed [buffer_size-1:0] leak;
    logic signed [buffer_size-1:0] noise_term;
    logic signed [EXT_W-1:0]       v_sum;
    logic signed [buffer_size-1:0] v_sat;
    logic signed [buffer_size-1:0] v_nx;
    logic [7:0]                    refr_nx;
    logic                          spike_bit;

    // Single shared datapath for the neuron selected by idx.
    always_comb begin
        v_cur      = v_mem[idx];
        leak       = v_cur >>> LEAK_SHIFT;
        noise_term = noise_snap[idx] >>> NOISE_SHIFT;
        v_sum      = {{2{v_cur[buffer_size-1]}}, v_cur}
                   - {{2{leak[buffer_size-1]}}, leak}
                   + {{2{syn_snap[idx][buffer_size-1]}}, syn_snap[idx]}
                   + {{2{noise_term[buffer_size-1]}}, noise_term};

        if (v_sum > SAT_MAX) begin
            v_sat = SAT_MAX[buffer_size-1:0];
        end else if (v_sum < SAT_MIN) begin
            v_sat = SAT_MIN[buffer_size-1:0];
        end else begin
            v_sat = v_sum[buffer_size-1:0];
        end

        refr_nx   = refr[idx];
        v_nx      = v_sat;
        spike_bit = 1'b0;
        if (refr[idx] != 8'd0) begin
            refr_nx = refr[idx] - 8'd1;
            v_nx    = RST_V;
        end else if (v_sat >= THR_V) begin
            spike_bit = 1'b1;
            v_nx      = RST_V;
            refr_nx   = REFR_LOAD;
        end

        spike_acc_nx      = spike_acc;
        spike_acc_nx[idx] = spike_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        noise_adv = 1'b0;
        case (state)
            S_IDLE: begin
                if (step) begin
                    state_nx = S_UPD;
                end
            end
            S_UPD: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                noise_adv = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // spikes is loaded on the last update so it is already valid during done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            spike_acc <= '0;
            spikes    <= '0;
            for (int unsigned i = 0; i < Num_Neurons; i++) begin
                v_mem[i]      <= RST_V;
                refr[i]       <= '0;
                noise_snap[i] <= '0;
                syn_snap[i]   <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (step) begin
                        idx       <= '0;
                        spike_acc <= '0;
                        for (int unsigned i = 0; i < Num_Neurons; i++) begin
                            noise_snap[i] <= noise_array[i*buffer_size +: buffer_size];
                            syn_snap[i]   <= syn_array[i*buffer_size +: buffer_size];
                        end
                    end
                end
                S_UPD: begin
                    v_mem[idx] <= v_nx;
                    refr[idx]  <= refr_nx;
                    spike_acc  <= spike_acc_nx;
                    idx        <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        spikes <= spike_acc_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_update.sv
// Scoreboard bench for lif_neuron_update: a behavioural neuron model predicts the
// spike vector of every timestep, checked when done pulses.
module tb_lif_neuron_update;

    localparam int N = 16;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           step;
    logic [N*W-1:0] noise_array;
    logic [N*W-1:0] syn_array;
    logic [N-1:0]   spikes;
    logic           busy;
    logic           done;
    logic           noise_adv;

    logic [W-1:0]   noise_w [N];
    logic [W-1:0]   syn_w   [N];
    longint         m_v     [N];
    int             m_refr  [N];
    logic [N-1:0]   exp_q   [$];
    int             total = 0;
    int             bad   = 0;

    lif_neuron_update #(
        .buffer_size (W),
        .Num_Neurons (N),
        .THRESHOLD   (1000),
        .V_RESET     (0),
        .LEAK_SHIFT  (4),
        .NOISE_SHIFT (8),
        .REFRACT     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .step        (step),
        .noise_array (noise_array),
        .syn_array   (syn_array),
        .spikes      (spikes),
        .busy        (busy),
        .done        (done),
        .noise_adv   (noise_adv)
    );

    always #5 clk = ~clk;

    always_comb begin
        noise_array = '0;
        syn_array   = '0;
        for (int i = 0; i < N; i++) begin
            noise_array[i*W +: W] = noise_w[i];
            syn_array[i*W +: W]   = syn_w[i];
        end
    end

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            noise_w[i] = '0;
            syn_w[i]   = '0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i]    = 0;
            m_refr[i] = 0;
        end
    endtask

    task automatic model_step(output logic [N-1:0] sp);
        longint nv;
        sp = '0;
        for (int i = 0; i < N; i++) begin
            if (m_refr[i] > 0) begin
                m_refr[i] = m_refr[i] - 1;
                m_v[i]    = 0;
            end else begin
                nv = m_v[i] - (m_v[i] >>> 4) + longint'($signed(syn_w[i]))
                   + (longint'($signed(noise_w[i])) >>> 8);
                if (nv > 64'sd2147483647)  nv = 64'sd2147483647;
                if (nv < -64'sd2147483648) nv = -64'sd2147483648;
                if (nv >= 1000) begin
                    sp[i]     = 1'b1;
                    m_v[i]    = 0;
                    m_refr[i] = 3;
                end else begin
                    m_v[i] = nv;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic do_step(input int stray_at, input bit glitch);
        logic [N-1:0] exp_sp;
        logic [N-1:0] popped;
        int           cyc;
        int           busy_cycles;
        bit           seen;
        step = 1'b1;
        model_step(exp_sp);
        exp_q.push_back(exp_sp);
        @(negedge clk);
        step        = 1'b0;
        cyc         = 1;
        busy_cycles = 0;
        seen        = 1'b0;
        while (!seen && cyc <= 40) begin
            step = (cyc == stray_at);
            if (glitch && cyc == 3) begin
                syn_w[2]   = 32'd5000;
                noise_w[2] = 32'h7fff_ffff;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cycles++;
                @(negedge clk);
                cyc++;
            end
        end
        step = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL step_timeout: no done within 40 cycles, required done at cycle 17");
            if (exp_q.size() > 0) popped = exp_q.pop_front();
        end else begin
            total++;
            if (cyc != 17 || busy_cycles != 16) begin
                bad++;
                $display("FAIL latency: done at cycle %0d with %0d busy cycles, required 17 and 16",
                         cyc, busy_cycles);
            end
            total++;
            if (noise_adv !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL done_flags: noise_adv=%b busy=%b, required 1 0", noise_adv, busy);
            end
            popped = exp_q.pop_front();
            total++;
            if (spikes !== popped) begin
                bad++;
                $display("FAIL spikes: got %h, required %h", spikes, popped);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || noise_adv !== 1'b0) begin
                bad++;
                $display("FAIL pulse_width: done=%b noise_adv=%b after done cycle, required 0 0",
                         done, noise_adv);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step  = 1'b0;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        #2;
        total++;
        if ({spikes, busy, done, noise_adv} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: spikes=%h busy=%b done=%b noise_adv=%b, required all 0",
                     spikes, busy, done, noise_adv);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        syn_w[0] = 32'd5;
        do_step(0, 1'b0);
        total++;
        if (dut.v_mem[0] !== 32'sd5) begin
            bad++;
            $display("FAIL reset_first_v0: got %0d, required 5", $signed(dut.v_mem[0]));
        end
        syn_w[0] = '0;
    endtask

    task automatic test_refractory();
        logic [5:0] pat;
        pat      = 6'b010001;
        syn_w[0] = 32'd1000;
        for (int k = 0; k < 6; k++) begin
            do_step(0, 1'b0);
            total++;
            if (spikes[0] !== pat[k]) begin
                bad++;
                $display("FAIL refractory_step%0d: spikes[0]=%b, required %b", k + 1, spikes[0], pat[k]);
            end
            total++;
            if (spikes[N-1:1] !== '0) begin
                bad++;
                $display("FAIL refractory_others: spikes[15:1]=%h, required 0", spikes[N-1:1]);
            end
        end
        syn_w[0] = '0;
    endtask

    task automatic test_pos_noise();
        noise_w[3] = 32'h0000_0A00;
        do_step(0, 1'b0);
        total++;
        if (dut.v_mem[3] !== 32'sd10) begin
            bad++;
            $display("FAIL pos_noise_v1: got %0d, required 10", $signed(dut.v_mem[3]));
        end
        do_step(0, 1'b0);
        total++;
        if (dut.v_mem[3] !== 32'sd20 || spikes[3] !== 1'b0) begin
            bad++;
            $display("FAIL pos_noise_v2: v=%0d spike=%b, required 20 0", $signed(dut.v_mem[3]), spikes[3]);
        end
        noise_w[3] = '0;
    endtask

    task automatic test_neg_noise();
        noise_w[5] = 32'hFFFF_F000;
        do_step(0, 1'b0);
        total++;
        if (dut.v_mem[5] !== -32'sd16) begin
            bad++;
            $display("FAIL neg_noise_v1: got %0d, required -16", $signed(dut.v_mem[5]));
        end
        do_step(0, 1'b0);
        total++;
        if (dut.v_mem[5] !== -32'sd31) begin
            bad++;
            $display("FAIL neg_noise_v2: got %0d, required -31", $signed(dut.v_mem[5]));
        end
        noise_w[5] = '0;
    endtask

    task automatic test_saturation();
        syn_w[7] = 32'h8000_0000;
        for (int k = 0; k < 2; k++) begin
            do_step(0, 1'b0);
            total++;
            if (dut.v_mem[7] !== 32'h8000_0000 || spikes[7] !== 1'b0) begin
                bad++;
                $display("FAIL saturation_step%0d: v=%h spike=%b, required 80000000 0",
                         k + 1, dut.v_mem[7], spikes[7]);
            end
        end
        syn_w[7] = '0;
    endtask

    task automatic test_snapshot();
        do_step(0, 1'b1);
        total++;
        if (dut.v_mem[2] !== 32'(m_v[2])) begin
            bad++;
            $display("FAIL snapshot_v2: got %0d, required %0d", $signed(dut.v_mem[2]), m_v[2]);
        end
        clear_inputs();
    endtask

    task automatic test_handshake();
        int extra_done;
        syn_w[1] = 32'd2000;
        do_step(5, 1'b0);
        syn_w[1]   = '0;
        extra_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        total++;
        if (extra_done != 0) begin
            bad++;
            $display("FAIL stray_step: %0d extra done pulses, required 0", extra_done);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        int nonzero_v;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total++;
        if ({spikes, busy, done, noise_adv} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: spikes=%h busy=%b done=%b noise_adv=%b, required all 0",
                     spikes, busy, done, noise_adv);
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1 || spikes !== '0) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL reset_mid_abort: %0d cycles with done or spikes set, required 0", dones);
        end
        nonzero_v = 0;
        for (int i = 0; i < N; i++) begin
            if (dut.v_mem[i] !== 32'sd0) nonzero_v++;
        end
        total++;
        if (nonzero_v != 0) begin
            bad++;
            $display("FAIL reset_mid_membrane: %0d membranes not at reset value, required 0", nonzero_v);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                s          = int'($urandom_range(1400)) - 200;
                syn_w[i]   = s;
                noise_w[i] = $urandom;
            end
            do_step(0, 1'b0);
        end
        clear_inputs();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_refractory();
        test_pos_noise();
        test_neg_noise();
        test_saturation();
        test_snapshot();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
